// File: rtl/hazard_tracker.sv
// Pipeline tag tracker feeding the hazard unit: advances D->X->M destination tags, inserts X bubbles,
// and freezes the front end while a multi-cycle FP op occupies X. Optional counters under HZT_PERF_EN.
module hazard_tracker #(
  parameter int REG_W   = 5,
  parameter int FPU_LAT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [REG_W-1:0] d_rd,
  input  logic [REG_W-1:0] d_fd,
  input  logic             d_read_mem,
  input  logic             d_fpu_op,
  input  logic             stall_d,
  input  logic             flush,
  output logic [REG_W-1:0] x_rd,
  output logic [REG_W-1:0] m_rd,
  output logic [REG_W-1:0] x_fd,
  output logic [REG_W-1:0] m_fd,
  output logic             x_read_mem,
  output logic             en_if,
  output logic             en_d,
  output logic             bubble_x,
  output logic             fpu_busy
`ifdef HZT_PERF_EN
  ,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_fpu_cnt
`endif
);

  logic [3:0]       fpu_cnt;
  logic [3:0]       fpu_cnt_next;
  logic [REG_W-1:0] x_rd_next;
  logic [REG_W-1:0] x_fd_next;
  logic             x_read_mem_next;
  logic [REG_W-1:0] m_rd_next;
  logic [REG_W-1:0] m_fd_next;
  logic             bubble_x_next;

  always_comb begin
    x_rd_next       = x_rd;
    x_fd_next       = x_fd;
    x_read_mem_next = x_read_mem;
    m_rd_next       = m_rd;
    m_fd_next       = m_fd;
    bubble_x_next   = 1'b0;
    fpu_cnt_next    = fpu_cnt;
    if (fpu_busy) begin
      // X is frozen on the FP op; M sees bubbles until the countdown expires.
      m_rd_next    = '0;
      m_fd_next    = '0;
      fpu_cnt_next = fpu_cnt - 4'd1;
    end else begin
      m_rd_next = x_rd;
      m_fd_next = x_fd;
      if (flush || stall_d) begin
        x_rd_next       = '0;
        x_fd_next       = '0;
        x_read_mem_next = 1'b0;
        bubble_x_next   = 1'b1;
      end else if (d_valid) begin
        x_rd_next       = d_rd;
        x_fd_next       = d_fd;
        x_read_mem_next = d_read_mem;
        if (d_fpu_op && (FPU_LAT > 1)) fpu_cnt_next = 4'(FPU_LAT - 1);
      end else begin
        x_rd_next       = '0;
        x_fd_next       = '0;
        x_read_mem_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_rd       <= '0;
      x_fd       <= '0;
      x_read_mem <= 1'b0;
      m_rd       <= '0;
      m_fd       <= '0;
      bubble_x   <= 1'b0;
      fpu_cnt    <= '0;
      fpu_busy   <= 1'b0;
    end else begin
      x_rd       <= x_rd_next;
      x_fd       <= x_fd_next;
      x_read_mem <= x_read_mem_next;
      m_rd       <= m_rd_next;
      m_fd       <= m_fd_next;
      bubble_x   <= bubble_x_next;
      fpu_cnt    <= fpu_cnt_next;
      fpu_busy   <= (fpu_cnt_next != 4'd0);
    end
  end

  // Flush overrides a stall request, so a redirect never holds the front end.
  assign en_if = ~(fpu_busy | (stall_d & ~flush));
  assign en_d  = en_if;

`ifdef HZT_PERF_EN
  logic [1:0]  perf_hit;
  logic [63:0] perf_flat;

  assign perf_hit[0] = stall_d & ~flush & ~fpu_busy;
  assign perf_hit[1] = fpu_busy;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
      logic [31:0] cnt;
      always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else if (perf_hit[gi] && (cnt != 32'hFFFF_FFFF)) cnt <= cnt + 32'd1;
      end
      assign perf_flat[gi*32 +: 32] = cnt;
    end
  endgenerate

  assign perf_stall_cnt = perf_flat[31:0];
  assign perf_fpu_cnt   = perf_flat[63:32];
`endif

endmodule
